// File: rtl/snn_aer_pkg.sv
// Shared types and constants for the spike AER transmit/receive path.
package snn_aer_pkg;

  // Default spike vector width (number of neurons).
  localparam int AER_N_DEFAULT = 96;

  // Default timestep stamp width.
  localparam int AER_TS_W_DEFAULT = 16;

  // Width of the dropped-step counter.
  localparam int AER_DROP_W = 16;

  // Address carried on the end-of-step marker beat.
  localparam int AER_EOS_ADDR = 0;

  // Transmit FSM: IDLE = no working step, SCAN = spikes left to send,
  // EOS = all spikes sent, marker beat still owed.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EOS  = 2'd2
  } aer_tx_state_t;

  // Saturating increment for the drop counter: holds at all-ones.
  function automatic logic [AER_DROP_W-1:0] sat_inc(input logic [AER_DROP_W-1:0] v);
    logic [AER_DROP_W-1:0] r;
    if (v == {AER_DROP_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(AER_DROP_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/snn_spike_aer_tx_if.sv
// AER stream bus: one beat per spike plus an end-of-step marker, valid/ready.
interface snn_spike_aer_tx_if #(
  parameter int AW   = $clog2(snn_aer_pkg::AER_N_DEFAULT),
  parameter int TS_W = snn_aer_pkg::AER_TS_W_DEFAULT
) ();

  logic            aer_valid;
  logic            aer_ready;
  logic [AW-1:0]   aer_addr;
  logic            aer_eos;
  logic [TS_W-1:0] aer_ts;

  // Transmitter side drives the beat, sink drives ready.
  modport master (
    output aer_valid,
    output aer_addr,
    output aer_eos,
    output aer_ts,
    input  aer_ready
  );

  // Receiver side (logger or on-chip router).
  modport slave (
    input  aer_valid,
    input  aer_addr,
    input  aer_eos,
    input  aer_ts,
    output aer_ready
  );

endinterface

// File: rtl/snn_prio_enc.sv
// Lowest-set-bit priority encoder; shared with the AER receive/decode side.
module snn_prio_enc
  import snn_aer_pkg::*;
#(
  parameter int  N  = AER_N_DEFAULT,
  localparam int AW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  output logic [AW-1:0] idx,
  output logic          nonzero
);

  logic found;

  // Walk upward, latching the first set index seen; later bits cannot override it.
  always_comb begin
    idx   = {AW{1'b0}};
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx   = (vec[i] && !found) ? AW'(i) : idx;
      found = found | vec[i];
    end
    nonzero = found;
  end

endmodule

// File: rtl/snn_spike_aer_tx.sv
// Spike vector to AER stream serializer with working + pending step buffers.
// Each step yields one beat per set bit (lowest index first) and one EOS beat.
module snn_spike_aer_tx
  import snn_aer_pkg::*;
#(
  parameter int  N    = AER_N_DEFAULT,
  parameter int  TS_W = AER_TS_W_DEFAULT,
  localparam int AW   = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  step_valid,
  input  logic [N-1:0]          spikes_vec,
  output logic                  step_ready,
  input  logic                  flush,
  snn_spike_aer_tx_if.master    aer,
  output logic                  busy,
  output logic                  overflow,
  output logic [AER_DROP_W-1:0] drop_cnt
);

  localparam logic [N-1:0]    VEC_ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [TS_W-1:0] TS_ONE  = {{(TS_W-1){1'b0}}, 1'b1};

  aer_tx_state_t         state_r, state_s;
  logic [N-1:0]          work_vec_r, work_vec_s;
  logic [TS_W-1:0]       work_ts_r, work_ts_s;
  logic [N-1:0]          pend_vec_r, pend_vec_s;
  logic [TS_W-1:0]       pend_ts_r, pend_ts_s;
  logic                  pvalid_r, pvalid_s;
  logic [TS_W-1:0]       ts_cnt_r, ts_cnt_s;
  logic                  overflow_r, overflow_s;
  logic [AER_DROP_W-1:0] drop_cnt_r, drop_cnt_s;

  logic                  aer_valid_r, aer_valid_s;
  logic [AW-1:0]         aer_addr_r, aer_addr_s;
  logic                  aer_eos_r, aer_eos_s;
  logic [TS_W-1:0]       aer_ts_r, aer_ts_s;
  logic                  step_ready_r, step_ready_s;
  logic                  busy_r, busy_s;

  logic                  hs_s;
  logic                  work_free_s;
  logic [N-1:0]          scan_vec_s;
  logic [AW-1:0]         enc_idx_s;
  logic                  enc_nz_s;

  // The outgoing beat is precomputed from the next working vector so aer_* stay registered.
  snn_prio_enc #(.N(N)) u_prio_enc (
    .vec     (work_vec_s),
    .idx     (enc_idx_s),
    .nonzero (enc_nz_s)
  );

  // A beat is consumed when the registered valid meets the sink's ready.
  always_comb begin
    hs_s       = aer_valid_r & aer.aer_ready;
    scan_vec_s = work_vec_r & (work_vec_r - VEC_ONE);
  end

  // Next-state logic: scan progress, working/pending loading, drops and flush.
  always_comb begin
    state_s     = state_r;
    work_vec_s  = work_vec_r;
    work_ts_s   = work_ts_r;
    pend_vec_s  = pend_vec_r;
    pend_ts_s   = pend_ts_r;
    pvalid_s    = pvalid_r;
    overflow_s  = overflow_r;
    drop_cnt_s  = drop_cnt_r;
    work_free_s = 1'b0;
    if (step_valid) begin
      ts_cnt_s = ts_cnt_r + TS_ONE;
    end else begin
      ts_cnt_s = ts_cnt_r;
    end

    if (flush) begin
      // Discard both buffers; an input step this cycle is neither kept nor counted as a drop.
      state_s    = IDLE;
      work_vec_s = {N{1'b0}};
      work_ts_s  = {TS_W{1'b0}};
      pend_vec_s = {N{1'b0}};
      pend_ts_s  = {TS_W{1'b0}};
      pvalid_s   = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          work_free_s = 1'b1;
        end
        SCAN: begin
          if (hs_s) begin
            work_vec_s = scan_vec_s;
            state_s    = (scan_vec_s != {N{1'b0}}) ? SCAN : EOS;
          end else begin
            state_s = SCAN;
          end
        end
        EOS: begin
          if (hs_s) begin
            work_free_s = 1'b1;
          end else begin
            state_s = EOS;
          end
        end
        default: begin
          work_free_s = 1'b1;
        end
      endcase

      if (work_free_s) begin
        if (pvalid_r) begin
          // Pending moves up; a new step can refill pending in the same cycle.
          work_vec_s = pend_vec_r;
          work_ts_s  = pend_ts_r;
          state_s    = (pend_vec_r != {N{1'b0}}) ? SCAN : EOS;
          if (step_valid) begin
            pend_vec_s = spikes_vec;
            pend_ts_s  = ts_cnt_r;
            pvalid_s   = 1'b1;
          end else begin
            pvalid_s   = 1'b0;
          end
        end else if (step_valid) begin
          work_vec_s = spikes_vec;
          work_ts_s  = ts_cnt_r;
          state_s    = (spikes_vec != {N{1'b0}}) ? SCAN : EOS;
        end else begin
          work_vec_s = {N{1'b0}};
          work_ts_s  = {TS_W{1'b0}};
          state_s    = IDLE;
        end
      end else if (step_valid) begin
        if (!pvalid_r) begin
          pend_vec_s = spikes_vec;
          pend_ts_s  = ts_cnt_r;
          pvalid_s   = 1'b1;
        end else begin
          overflow_s = 1'b1;
          drop_cnt_s = sat_inc(drop_cnt_r);
        end
      end else begin
        pvalid_s = pvalid_r;
      end
    end
  end

  // Output beat and status for the next cycle, derived from the next buffer contents.
  always_comb begin
    aer_valid_s  = (state_s != IDLE);
    aer_eos_s    = (state_s == EOS);
    if ((state_s == SCAN) && enc_nz_s) begin
      aer_addr_s = enc_idx_s;
    end else begin
      aer_addr_s = AW'(AER_EOS_ADDR);
    end
    if (state_s != IDLE) begin
      aer_ts_s = work_ts_s;
    end else begin
      aer_ts_s = {TS_W{1'b0}};
    end
    step_ready_s = !pvalid_s;
    busy_s       = (state_s != IDLE) || pvalid_s;
  end

  // State, buffers and registered outputs; reset aborts any stream in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= IDLE;
      work_vec_r   <= {N{1'b0}};
      work_ts_r    <= {TS_W{1'b0}};
      pend_vec_r   <= {N{1'b0}};
      pend_ts_r    <= {TS_W{1'b0}};
      pvalid_r     <= 1'b0;
      ts_cnt_r     <= {TS_W{1'b0}};
      overflow_r   <= 1'b0;
      drop_cnt_r   <= {AER_DROP_W{1'b0}};
      aer_valid_r  <= 1'b0;
      aer_addr_r   <= {AW{1'b0}};
      aer_eos_r    <= 1'b0;
      aer_ts_r     <= {TS_W{1'b0}};
      step_ready_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      work_vec_r   <= work_vec_s;
      work_ts_r    <= work_ts_s;
      pend_vec_r   <= pend_vec_s;
      pend_ts_r    <= pend_ts_s;
      pvalid_r     <= pvalid_s;
      ts_cnt_r     <= ts_cnt_s;
      overflow_r   <= overflow_s;
      drop_cnt_r   <= drop_cnt_s;
      aer_valid_r  <= aer_valid_s;
      aer_addr_r   <= aer_addr_s;
      aer_eos_r    <= aer_eos_s;
      aer_ts_r     <= aer_ts_s;
      step_ready_r <= step_ready_s;
      busy_r       <= busy_s;
    end
  end

  assign aer.aer_valid = aer_valid_r;
  assign aer.aer_addr  = aer_addr_r;
  assign aer.aer_eos   = aer_eos_r;
  assign aer.aer_ts    = aer_ts_r;
  assign step_ready    = step_ready_r;
  assign busy          = busy_r;
  assign overflow      = overflow_r;
  assign drop_cnt      = drop_cnt_r;

endmodule

// File: tb/tb_snn_spike_aer_tx.sv
// Self-checking bench for snn_spike_aer_tx: directed scenarios plus random
// traffic, compared against a queue-of-steps reference model.
module tb_snn_spike_aer_tx;
  import snn_aer_pkg::*;

  localparam int N    = 96;
  localparam int TS_W = 16;
  localparam int AW   = 7;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          step_valid = 1'b0;
  logic [N-1:0]  spikes_vec = '0;
  logic          flush = 1'b0;
  logic          step_ready;
  logic          busy;
  logic          overflow;
  logic [15:0]   drop_cnt;

  snn_spike_aer_tx_if #(.AW(AW), .TS_W(TS_W)) aer_bus ();

  snn_spike_aer_tx #(.N(N), .TS_W(TS_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .step_valid (step_valid),
    .spikes_vec (spikes_vec),
    .step_ready (step_ready),
    .flush      (flush),
    .aer        (aer_bus),
    .busy       (busy),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a FIFO of at most two steps (working first, pending second).
  typedef struct {
    logic [N-1:0]    vec;
    logic [TS_W-1:0] ts;
  } step_t;

  step_t           mq[$];
  logic [TS_W-1:0] m_ts;
  logic            m_ovf;
  int              m_drop;
  bit              m_live;

  int n_cmp = 0;
  int n_mis = 0;

  int log_addr[$];
  bit log_eos[$];
  int log_ts[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int low_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  function automatic logic [N-1:0] rand_vec();
    logic [N-1:0] v;
    case ($urandom_range(0, 4))
      0: v = '0;
      1: v = '1;
      2: begin
        v = '0;
        v[$urandom_range(0, N-1)] = 1'b1;
      end
      default: v = {$urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom}
                 & {$urandom, $urandom, $urandom};
    endcase
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ts   = '0;
    m_ovf  = 1'b0;
    m_drop = 0;
    m_live = 1'b0;
  endtask

  // Compare the DUT outputs of the current cycle with the model, away from the edge.
  task automatic check_outputs();
    bit exp_valid;
    exp_valid = (mq.size() > 0);
    check_val("aer_valid", aer_bus.aer_valid, exp_valid);
    if (exp_valid) begin
      check_val("aer_eos", aer_bus.aer_eos, (mq[0].vec == '0));
      check_val("aer_addr", aer_bus.aer_addr, (mq[0].vec == '0) ? 0 : low_idx(mq[0].vec));
      check_val("aer_ts", aer_bus.aer_ts, mq[0].ts);
    end
    check_val("step_ready", step_ready, m_live ? (mq.size() < 2) : 0);
    check_val("busy", busy, (mq.size() > 0));
    check_val("overflow", overflow, m_ovf);
    check_val("drop_cnt", drop_cnt, (m_drop > 65535) ? 65535 : m_drop);
    if (aer_bus.aer_valid && aer_bus.aer_ready && !flush) begin
      log_addr.push_back(int'(aer_bus.aer_addr));
      log_eos.push_back(aer_bus.aer_eos);
      log_ts.push_back(int'(aer_bus.aer_ts));
    end
  endtask

  // Apply this cycle's inputs to the model at the clock edge.
  task automatic model_edge();
    logic [N-1:0] v;
    step_t s;
    m_live = 1'b1;
    s.vec = spikes_vec;
    s.ts  = m_ts;
    if (step_valid) m_ts = m_ts + 16'd1;
    if (flush) begin
      mq.delete();
    end else begin
      if (mq.size() > 0 && aer_bus.aer_ready) begin
        if (mq[0].vec != '0) begin
          v = mq[0].vec;
          v[low_idx(v)] = 1'b0;
          mq[0].vec = v;
        end else begin
          void'(mq.pop_front());
        end
      end
      if (step_valid) begin
        if (mq.size() < 2) begin
          mq.push_back(s);
        end else begin
          m_ovf = 1'b1;
          m_drop++;
        end
      end
    end
  endtask

  // One clock cycle: drive, check at negedge, advance model at posedge.
  task automatic cycle(input bit sv, input logic [N-1:0] v, input bit rdy, input bit fl);
    step_valid        = sv;
    spikes_vec        = v;
    aer_bus.aer_ready = rdy;
    flush             = fl;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    step_valid = 1'b0;
    flush      = 1'b0;
    rstn       = 1'b0;
    #1;
    check_val("rst_aer_valid", aer_bus.aer_valid, 0);
    check_val("rst_aer_addr", aer_bus.aer_addr, 0);
    check_val("rst_aer_eos", aer_bus.aer_eos, 0);
    check_val("rst_aer_ts", aer_bus.aer_ts, 0);
    check_val("rst_step_ready", step_ready, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_overflow", overflow, 0);
    check_val("rst_drop_cnt", drop_cnt, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    logic [N-1:0] v;
    aer_bus.aer_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    idle(2, 1'b0);

    // Single step {3,17,95}: four consecutive beats, all ts=0.
    log_addr.delete(); log_eos.delete(); log_ts.delete();
    v = '0; v[3] = 1'b1; v[17] = 1'b1; v[95] = 1'b1;
    cycle(1'b1, v, 1'b1, 1'b0);
    idle(6, 1'b1);
    check_val("t1_nbeats", log_addr.size(), 4);
    if (log_addr.size() == 4) begin
      check_val("t1_a0", log_addr[0], 3);
      check_val("t1_a1", log_addr[1], 17);
      check_val("t1_a2", log_addr[2], 95);
      check_val("t1_eos", log_eos[3], 1);
      check_val("t1_ts", log_ts[3], 0);
    end

    // Empty step: exactly one EOS beat at ts=1; the following step is ts=2.
    log_addr.delete(); log_eos.delete(); log_ts.delete();
    cycle(1'b1, '0, 1'b1, 1'b0);
    idle(3, 1'b1);
    check_val("t2_nbeats", log_addr.size(), 1);
    if (log_addr.size() == 1) begin
      check_val("t2_eos", log_eos[0], 1);
      check_val("t2_ts", log_ts[0], 1);
    end
    cycle(1'b1, 96'h1, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Backpressure on a two-spike step.
    v = '0; v[5] = 1'b1; v[6] = 1'b1;
    cycle(1'b1, v, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Overflow: three back-to-back steps with the sink stalled.
    for (int i = 0; i < 3; i++) cycle(1'b1, 96'h1, 1'b0, 1'b0);
    idle(6, 1'b1);
    check_val("t4_overflow", overflow, 1);
    check_val("t4_drop_cnt", drop_cnt, 1);
    cycle(1'b1, 96'h1, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Back-to-back full-rate all-ones steps.
    for (int i = 0; i < 300; i++) cycle(1'b1, '1, 1'b1, 1'b0);
    idle(200, 1'b1);

    // Flush mid-scan after two beats of a ten-spike step.
    cycle(1'b1, 96'h3FF << 20, 1'b1, 1'b0);
    idle(2, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    idle(2, 1'b1);
    cycle(1'b1, 96'h3, 1'b1, 1'b0);
    idle(4, 1'b1);

    // Same again, but aborted by reset; ts restarts at 0.
    cycle(1'b1, 96'h3FF << 40, 1'b1, 1'b0);
    idle(2, 1'b1);
    do_reset();
    idle(1, 1'b1);
    log_addr.delete(); log_eos.delete(); log_ts.delete();
    cycle(1'b1, '0, 1'b1, 1'b0);
    idle(2, 1'b1);
    check_val("t6_nbeats", log_addr.size(), 1);
    if (log_addr.size() == 1) check_val("t6_ts", log_ts[0], 0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
        idle(1, 1'b1);
      end else begin
        cycle(($urandom_range(0, 2) == 0), rand_vec(), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 149) == 0));
      end
    end
    idle(250, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
